inst_mem_ctrl: RTL
==================

Name: inst_mem_ctrl

Overview:
- Parametrised, handshaked instruction memory for the multicycle MIPS core. Second generation of the current instruction memory.
- Adds the following over the fixed version:
  - configurable data width, depth and access latency;
  - byte- or word-addressing mode;
  - request/valid handshake with fault reporting;
  - a program-load write port used by benches and the boot loader.
- Sits between the PC/fetch stage and the instruction register.

Parameters:
- DATA_WIDTH, 32, instruction word width in bits.
- ADDR_WIDTH, 32, width of the fetch address.
- DEPTH, 256, number of instruction words. Must be a power of two, ≥ 2.
- LATENCY, 1, cycles from request acceptance to response. Legal range 1..8.
- BYTE_ADDR, 1:
  - 1: address is a byte address; word index = address >> 2, and address[1:0] must be 0.
  - 0: address is the word index directly.

Ports:
- clock, input, 1, single system clock; all state updates on its rising edge.
- reset_n, input, 1, synchronous active-low reset.
- req, input, 1, fetch request; qualified by ready.
- address, input, ADDR_WIDTH, fetch address; sampled when req && ready.
- ready, output, 1, controller can accept a request this cycle.
- inst_valid, output, 1, one-cycle pulse; inst and fault are valid.
- inst, output, DATA_WIDTH, fetched instruction word.
- fault, output, 1, the response belongs to an out-of-range or misaligned fetch.
- load_en, input, 1, program-load write enable.
- load_addr, input, $clog2(DEPTH), word index for the load write.
- load_data, input, DATA_WIDTH, word to write.

Behaviour:
- Reset: one clock; reset is synchronous and active-low. On a rising edge with reset_n = 0:
  - state becomes IDLE and the wait counter clears to 0;
  - inst_valid = 0, inst = 0, fault = 0, ready = 1 from the next cycle;
  - memory array contents are not cleared and are retained.
- Reset mid-operation: any pending fetch is discarded and no inst_valid is produced for it. A load_en on the same edge as reset is ignored.
- FSM states: IDLE, BUSY.
- IDLE: ready = 1.
  - req = 1 at edge N accepts the request.
  - The read is performed at edge N: data is taken from the array and the fault flag is computed.
  - If LATENCY = 1, the response is presented in the next cycle. Otherwise go to BUSY with counter = LATENCY-1.
- BUSY: ready = 0.
  - Counter decrements each edge.
  - When it reaches 1, the next edge presents the response and returns to IDLE.
- Response timing: inst_valid is high for exactly the one cycle following edge N+LATENCY-1, i.e. visible after LATENCY edges.
- ready during the response cycle: ready = 1, so a new request can be accepted in the same cycle inst_valid is high.
  - LATENCY = 1 therefore sustains one fetch per cycle.
  - LATENCY = L gives one fetch per L cycles.
- req while ready = 0 is ignored. There is no queueing and the address is not stored.
- fault = 1 when either condition holds:
  - the computed word index ≥ DEPTH (upper address bits nonzero);
  - BYTE_ADDR = 1 and address[1:0] != 0.
- On a faulting fetch: inst = 0 (MIPS NOP), with the same latency and inst_valid timing as a normal fetch.
- inst and fault hold their last response values while inst_valid = 0.
- Load port:
  - load_en = 1 writes mem[load_addr] <= load_data at the edge.
  - It operates independently of FSM state, every cycle.
- Same-edge fetch read and load write to the same index: the fetch returns the OLD word (read-before-write).
- A load to the index of an in-flight fetch (BUSY) does not change that fetch's captured data.
- Arithmetic: the word index is truncated to $clog2(DEPTH) bits only after the range check. No wrap-around aliasing is permitted.

Test Plan:
1. Load 0x20080005 to index 0 and 0x00000000 to index 1. With defaults, req with address 0x0 then 0x4 on back-to-back cycles. Required: inst_valid high on 2 consecutive cycles, with inst = 0x20080005 then 0x00000000, fault = 0, ready constantly 1.
2. LATENCY = 3, load 0xAC010004 to index 2, req with address 0x8. Required: ready = 0 for 2 cycles; inst_valid high only in the 3rd cycle after acceptance with inst = 0xAC010004. A req asserted during BUSY produces no extra response.
3. Defaults, req address 0x6, then 0x400. Required: two responses, each with fault = 1, inst = 0x0. BYTE_ADDR = 0 with address 0x6 returns mem[6] with fault = 0.
4. Index 3 holds 0x11111111; drive load_en (load_addr = 3, load_data = 0x22222222) on the same edge as req address 0xC. Required: inst = 0x11111111. A following fetch of 0xC returns 0x22222222.
5. LATENCY = 4, accept req, assert reset_n = 0 for one edge during BUSY. Required: no inst_valid ever; outputs 0; ready = 1 after reset; previously loaded words still read back correctly.
6. DEPTH = 16, load index 15 = 0xDEADBEEF, fetch 0x3C and 0x40. Required: first returns 0xDEADBEEF with fault = 0; second returns fault = 1 (no alias to index 0).

Source files
------------

// File: rtl/inst_mem_ctrl_if.sv
// Fetch handshake and program-load port between the fetch stage and the instruction memory.
interface inst_mem_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 256
);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic                  req;
  logic [ADDR_WIDTH-1:0] address;
  logic                  ready;
  logic                  inst_valid;
  logic [DATA_WIDTH-1:0] inst;
  logic                  fault;
  logic                  load_en;
  logic [IDX_W-1:0]      load_addr;
  logic [DATA_WIDTH-1:0] load_data;

  modport master (
    output req, address, load_en, load_addr, load_data,
    input  ready, inst_valid, inst, fault
  );

  modport slave (
    input  req, address, load_en, load_addr, load_data,
    output ready, inst_valid, inst, fault
  );
endinterface

// File: rtl/inst_mem_ctrl.sv
// Parametrised handshaked instruction memory: fetch with configurable latency,
// byte/word addressing, range/alignment fault reporting and a program-load write port.
module inst_mem_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned BYTE_ADDR  = 1
) (
  input logic            clock,
  input logic            reset_n,
  inst_mem_ctrl_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 4;

  if ((LATENCY < 1) || (LATENCY > 8)) begin : g_bad_latency
    $error("inst_mem_ctrl: LATENCY must be in 1..8");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("inst_mem_ctrl: DEPTH must be a power of two >= 2");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] pend_data;
  logic                  pend_fault;
  logic                  ready_q;
  logic                  inst_valid_q;
  logic [DATA_WIDTH-1:0] inst_q;
  logic                  fault_q;

  logic [ADDR_WIDTH-1:0] widx_c;
  logic                  fault_c;
  logic [DATA_WIDTH-1:0] rdata_c;

  // Range check runs on the full-width index; truncation only feeds the array lookup.
  always_comb begin
    widx_c  = '0;
    fault_c = 1'b0;
    rdata_c = '0;
    if (BYTE_ADDR != 0) begin
      widx_c  = bus.address >> 2;
      fault_c = (bus.address[1:0] != 2'b00);
    end else begin
      widx_c  = bus.address;
    end
    if ((widx_c >> IDX_W) != '0) begin
      fault_c = 1'b1;
    end
    if (!fault_c) begin
      rdata_c = mem[widx_c[IDX_W-1:0]];
    end
  end

  // Load port; the array has no reset and keeps its contents across reset.
  always_ff @(posedge clock) begin
    if (reset_n && bus.load_en) begin
      mem[bus.load_addr] <= bus.load_data;
    end
  end

  // Fetch FSM; the word is captured at acceptance so later loads cannot disturb it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      pend_data    <= '0;
      pend_fault   <= 1'b0;
      ready_q      <= 1'b1;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      fault_q      <= 1'b0;
    end else begin
      inst_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            if (LATENCY == 1) begin
              inst_q       <= rdata_c;
              fault_q      <= fault_c;
              inst_valid_q <= 1'b1;
              ready_q      <= 1'b1;
            end else begin
              pend_data  <= rdata_c;
              pend_fault <= fault_c;
              cnt        <= CNT_W'(LATENCY - 1);
              ready_q    <= 1'b0;
              state      <= BUSY;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt == CNT_W'(1)) begin
            inst_q       <= pend_data;
            fault_q      <= pend_fault;
            inst_valid_q <= 1'b1;
            ready_q      <= 1'b1;
            cnt          <= '0;
            state        <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready      = ready_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.inst       = inst_q;
  assign bus.fault      = fault_q;
endmodule
